// File: rtl/timer_pkg.sv
// Shared types and constants for the timer controller slice.
// State encoding plus counter-mux and terminal-compare selects.
package timer_pkg;

  typedef enum logic [2:0] {
    CLR,
    IDLE,
    LOAD,
    PRESET,
    RUN,
    PAUSE,
    DONE,
    RELOAD
  } state_e;

  localparam logic [1:0] SEL_LOAD_INIT = 2'd0;
  localparam logic [1:0] SEL_UP        = 2'd1;
  localparam logic [1:0] SEL_DOWN      = 2'd2;
  localparam logic [1:0] SEL_CLEAR     = 2'd3;

  localparam logic TC_EQ_INIT = 1'b0;
  localparam logic TC_ZERO    = 1'b1;

  function automatic logic [1:0] run_sel(
    input logic down
  );
    return down ? SEL_DOWN : SEL_UP;
  endfunction

  function automatic logic [1:0] preset_sel(
    input logic down
  );
    return down ? SEL_LOAD_INIT : SEL_CLEAR;
  endfunction

endpackage

// File: rtl/timer_controller_if.sv
// Controller <-> datapath bus: command strobes out, terminal flag in.
// master = controller, slave = datapath.
interface timer_controller_if;

  logic       init_ld_en;
  logic       count_en;
  logic [1:0] ctrSelect;
  logic       tcSelect;
  logic       anReset;
  logic       tcLimitReached;

  modport master (
    output init_ld_en,
    output count_en,
    output ctrSelect,
    output tcSelect,
    output anReset,
    input  tcLimitReached
  );

  modport slave (
    input  init_ld_en,
    input  count_en,
    input  ctrSelect,
    input  tcSelect,
    input  anReset,
    output tcLimitReached
  );

endinterface

// File: rtl/btn_sync_edge.sv
// Raw button -> SYNC_STAGES synchronizer -> registered rising-edge pulse.
// Ports: clk, reset (sync, active high), btn_i raw, pulse_o one cycle.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;
  logic                   pulse_q;
  logic                   pulse_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn_i};
    prev_d  = sync_out;
    pulse_d = sync_out & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/timer_controller.sv
// Timer control FSM: buttons + mode -> datapath command strobes.
// Ports: clk, reset (sync high), tick, load/start/stop_btn, mode,
//   dp (datapath bus, master), running, done, wrap_pulse.
// Build option: TIMER_AUTO_RELOAD_EN makes RUN wrap via RELOAD.
module timer_controller
  import timer_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic load_btn,
  input  logic start_btn,
  input  logic stop_btn,
  input  logic mode,
  timer_controller_if.master dp,
  output logic running,
  output logic done,
  output logic wrap_pulse
);

`ifdef TIMER_AUTO_RELOAD_EN
  localparam bit AutoReload = 1'b1;
`else
  localparam bit AutoReload = 1'b0;
`endif

  state_e     state_q;
  state_e     state_d;
  logic       mode_q;
  logic       mode_d;
  logic       load_p;
  logic       start_p;
  logic       stop_p;
  logic       tc;
  logic       ld_c;
  logic       cen_c;
  logic [1:0] sel_c;
  logic       an_c;
  logic       run_c;
  logic       done_c;
  logic       wrap_c;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (load_btn),
    .pulse_o(load_p)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (start_btn),
    .pulse_o(start_p)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_stop (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (stop_btn),
    .pulse_o(stop_p)
  );

  assign tc = dp.tcLimitReached;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLR;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // Button priority where pulses coincide: stop > load > start.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    unique case (state_q)
      CLR:    state_d = IDLE;
      IDLE: begin
        if (load_p)       state_d = LOAD;
        else if (start_p) state_d = tc ? DONE : RUN;
      end
      LOAD: begin
        mode_d  = mode;
        state_d = PRESET;
      end
      PRESET: state_d = IDLE;
      RUN: begin
        if (tc)          state_d = AutoReload ? RELOAD : DONE;
        else if (stop_p) state_d = PAUSE;
      end
      PAUSE: begin
        if (stop_p)       state_d = PRESET;
        else if (load_p)  state_d = LOAD;
        else if (start_p) state_d = RUN;
      end
      DONE: begin
        if (load_p) state_d = LOAD;
      end
      RELOAD: state_d = RUN;
    endcase
  end

  // Mux select parks at CLEAR whenever the counter is not enabled.
  always_comb begin
    ld_c   = 1'b0;
    cen_c  = 1'b0;
    sel_c  = SEL_CLEAR;
    an_c   = 1'b0;
    run_c  = 1'b0;
    done_c = 1'b0;
    wrap_c = 1'b0;
    unique case (state_q)
      CLR: begin
        cen_c = 1'b1;
        an_c  = 1'b1;
      end
      IDLE:  ;
      LOAD:  ld_c = 1'b1;
      PRESET: begin
        cen_c = 1'b1;
        sel_c = preset_sel(mode_q);
      end
      RUN: begin
        run_c = 1'b1;
        // Suppress the tick that lands on the terminal value.
        cen_c = tick & ~tc;
        if (cen_c) sel_c = run_sel(mode_q);
      end
      PAUSE: ;
      DONE:  done_c = 1'b1;
      RELOAD: begin
        cen_c  = 1'b1;
        sel_c  = preset_sel(mode_q);
        wrap_c = AutoReload;
      end
    endcase
  end

  assign dp.init_ld_en = ld_c;
  assign dp.count_en   = cen_c;
  assign dp.ctrSelect  = sel_c;
  assign dp.tcSelect   = mode_q ? TC_ZERO : TC_EQ_INIT;
  assign dp.anReset    = an_c;
  assign running       = run_c;
  assign done          = done_c;
  assign wrap_pulse    = wrap_c;

endmodule

// File: tb/tb_timer_controller.sv
// Bench for timer_controller with a behavioural counter datapath.
// Random load/run/pause/restart scenarios against arithmetic expectations.
module tb_timer_controller;

  localparam int SYNC = 2;
  // Raw press -> pulse (SYNC+1) -> state change one edge later.
  localparam int LAT  = SYNC + 2;
`ifdef TIMER_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b1;
  logic       load_btn = 1'b0;
  logic       start_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       mode = 1'b0;
  logic       running;
  logic       done;
  logic       wrap_pulse;
  logic [7:0] sw = 8'd0;
  logic [7:0] init_q = 8'd0;
  logic [7:0] cnt = 8'd0;
  int         checks = 0;
  int         failures = 0;

  timer_controller_if dp_if ();

  timer_controller #(.SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .load_btn  (load_btn),
    .start_btn (start_btn),
    .stop_btn  (stop_btn),
    .mode      (mode),
    .dp        (dp_if),
    .running   (running),
    .done      (done),
    .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  // Datapath: init register, counter with 4-way mux, terminal compare.
  always @(posedge clk) begin
    if (dp_if.init_ld_en) init_q <= sw;
    if (dp_if.count_en) begin
      case (dp_if.ctrSelect)
        2'd0:    cnt <= init_q;
        2'd1:    cnt <= cnt + 8'd1;
        2'd2:    cnt <= cnt - 8'd1;
        default: cnt <= 8'd0;
      endcase
    end
  end

  assign dp_if.tcLimitReached =
    dp_if.tcSelect ? (cnt == 8'd0) : (cnt == init_q);

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int b, input int h);
    case (b)
      0:       load_btn = 1'b1;
      1:       start_btn = 1'b1;
      default: stop_btn = 1'b1;
    endcase
    cyc(h);
    load_btn  = 1'b0;
    start_btn = 1'b0;
    stop_btn  = 1'b0;
  endtask

  // Expected counter value after j counting steps.
  function automatic int vexp(input int n, input bit md, input int j);
    return md ? n - j : j;
  endfunction

  task automatic do_load(input int n, input bit md);
    sw   = n[7:0];
    mode = md;
    press(0, $urandom_range(1, 100));
    cyc(LAT + 3);
    mode = ~md;
    chk("preset_cnt", cnt, vexp(n, md, 0));
    chk("idle_run", running, 0);
    chk("idle_done", done, 0);
    chk("idle_tcsel", dp_if.tcSelect, md);
  endtask

  task automatic run_phase(
    input  int n,
    input  bit md,
    input  int j0,
    input  int pause_at,
    input  int arm_wraps,
    input  bit both,
    output int jout,
    output bit paused
  );
    int j;
    int wraps;
    j      = j0;
    wraps  = 0;
    paused = 1'b0;
    for (int g = 0; g < 30 && !running; g++) cyc(1);
    chk("run_start", running, 1);
    for (int g = 0; g < 500 && running; g++) begin
      chk("run_cnt", cnt, vexp(n, md, j));
      chk("run_tcsel", dp_if.tcSelect, md);
      if (j == pause_at && wraps >= arm_wraps && !paused) begin
        stop_btn  = 1'b1;
        start_btn = both;
        paused    = 1'b1;
      end
      j++;
      cyc(1);
`ifdef TIMER_AUTO_RELOAD_EN
      if (!running && !paused) begin
        chk("wrap_pulse", wrap_pulse, 1);
        chk("wrap_done", done, 0);
        chk("wrap_cnt", cnt, vexp(n, md, n));
        j = 0;
        wraps++;
        cyc(1);
      end
`endif
    end
    chk("run_end", running, 0);
    if (paused) begin
      chk("pause_cnt", cnt, vexp(n, md, j));
      chk("pause_done", done, 0);
    end else begin
      chk("done", done, 1);
      chk("done_steps", j, n + 1);
      chk("done_cnt", cnt, vexp(n, md, n));
      cyc(20);
      chk("done_hold", cnt, vexp(n, md, n));
      chk("done_cen", dp_if.count_en, 0);
    end
    jout = j;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int pa;
    int jj;
    int h;
    bit md;
    bit paused;
    bit both;
    bit saw;

    cyc(1);
    chk("rst_cen", dp_if.count_en, 1);
    chk("rst_sel", dp_if.ctrSelect, 3);
    chk("rst_an", dp_if.anReset, 1);
    chk("rst_ld", dp_if.init_ld_en, 0);
    chk("rst_tcsel", dp_if.tcSelect, 0);
    chk("rst_run", running, 0);
    chk("rst_done", done, 0);
    chk("rst_wrap", wrap_pulse, 0);
    cyc(1);
    reset = 1'b0;
    chk("clr_cen", dp_if.count_en, 1);
    chk("clr_an", dp_if.anReset, 1);
    cyc(1);
    chk("idle_cen", dp_if.count_en, 0);
    chk("idle_an", dp_if.anReset, 0);
    chk("idle_ld", dp_if.init_ld_en, 0);
    chk("clr_cnt", cnt, 0);

    for (int it = 0; it < 12; it++) begin
      n  = $urandom_range(0, 12);
      md = 1'($urandom_range(0, 1));
      if (it == 0) begin n = 5;  md = 1'b1; end
      if (it == 1) begin n = 3;  md = 1'b0; end
      if (it == 2) begin n = 10; md = 1'b1; end
      if (it == 3) begin n = 0;  md = 1'b1; end
      if (AR && n != 0 && n < LAT + 1) n = LAT + 1;
      do_load(n, md);

      if (n == 0) begin
        saw = 1'b0;
        h   = $urandom_range(1, 100);
        start_btn = 1'b1;
        for (int k = 0; k < h + LAT + 2; k++) begin
          if (k == h) start_btn = 1'b0;
          cyc(1);
          if (running) saw = 1'b1;
        end
        start_btn = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_ran", saw, 0);
        chk("zero_cnt", cnt, 0);
        continue;
      end

      pa = -1;
      if (n >= LAT + 1 &&
          (it == 2 || it == 4 || AR || $urandom_range(0, 1) == 1))
        pa = $urandom_range(0, n - 1 - LAT);
      both = (it == 4) || ($urandom_range(0, 3) == 0);
      press(1, $urandom_range(1, 3));
      run_phase(n, md, 0, pa, AR ? 2 : 0, both, jj, paused);

      if (paused) begin
        h = (it == 2) ? 100 : $urandom_range(1, 100);
        cyc(h);
        stop_btn  = 1'b0;
        start_btn = 1'b0;
        cyc(LAT + 2);
        chk("hold_cnt", cnt, vexp(n, md, jj));
        chk("hold_run", running, 0);
        chk("hold_done", done, 0);
        chk("hold_cen", dp_if.count_en, 0);
        pa = AR ? $urandom_range(0, n - 1 - LAT) : -1;
        if ($urandom_range(0, 1) == 1) begin
          press(1, $urandom_range(1, 3));
          run_phase(n, md, jj, pa, AR ? 1 : 0, 1'b0, jj, paused);
        end else begin
          press(2, $urandom_range(1, 3));
          cyc(LAT + 2);
          chk("restart_cnt", cnt, vexp(n, md, 0));
          chk("restart_run", running, 0);
          press(1, $urandom_range(1, 3));
          run_phase(n, md, 0, pa, AR ? 1 : 0, 1'b0, jj, paused);
        end
      end
    end

    do_load(10, 1'b1);
    press(1, 1);
    for (int g = 0; g < 40 && !(running && cnt == 8'd4); g++) cyc(1);
    chk("rst_reach", cnt, 4);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("mid_cen", dp_if.count_en, 1);
    chk("mid_sel", dp_if.ctrSelect, 3);
    chk("mid_an", dp_if.anReset, 1);
    chk("mid_ld", dp_if.init_ld_en, 0);
    chk("mid_run", running, 0);
    chk("mid_done", done, 0);
    chk("mid_cnt", cnt, 3);
    cyc(1);
    chk("mid_cnt0", cnt, 0);
    chk("mid_tcsel", dp_if.tcSelect, 0);
    chk("mid_idle", dp_if.count_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
